// File: rtl/ula_seq.sv
// Sequential ALU: add/sub/logic finish in one cycle; MUL (shift-add) and
// DIV/MOD (restoring division) iterate one bit per cycle for WIDTH cycles.
module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ula_operation,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_ADD  = 4'd1,  OP_SUB  = 4'd2,  OP_MUL  = 4'd3,
                         OP_DIV  = 4'd4,  OP_MOD  = 4'd5,  OP_AND  = 4'd6,
                         OP_OR   = 4'd7,  OP_XOR  = 4'd8,  OP_NOT  = 4'd9,
                         OP_NOR  = 4'd10, OP_NAND = 4'd11, OP_XNOR = 4'd12;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nx;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] dv_q, acc_lo, acc_hi;
  logic [CW-1:0]    cnt;

  logic             accept, iter_op, last_iter;
  logic             sc_c, sc_v, sc_valid, qbit, it_c;
  logic [WIDTH:0]   sum, dif, msum, rem_sh, trial;
  logic [WIDTH-1:0] sc_res, it_res, nx_lo, nx_hi;
  logic [3:0]       sc_flg, it_flg;

  assign accept    = start && (state != CALC);
  assign last_iter = (cnt == CW'(WIDTH-1));
  assign busy      = (state == CALC);
  assign done      = (state == DONE);

  // Single-cycle results, taken straight from the inputs on the accepting edge
  always_comb begin
    sum      = {1'b0, operand1} + {1'b0, operand2};
    dif      = {1'b0, operand1} - {1'b0, operand2};
    sc_res   = '0;
    sc_c     = 1'b0;
    sc_v     = 1'b0;
    sc_valid = 1'b1;
    iter_op  = 1'b0;
    case (ula_operation)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (operand1[WIDTH-1] == operand2[WIDTH-1]) && (sum[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = dif[WIDTH-1:0];
        sc_c   = dif[WIDTH];
        sc_v   = (operand1[WIDTH-1] != operand2[WIDTH-1]) && (dif[WIDTH-1] != operand1[WIDTH-1]);
      end
      OP_MUL:         iter_op = 1'b1;
      OP_DIV, OP_MOD: if (operand2 == '0) sc_c = 1'b1; else iter_op = 1'b1;
      OP_AND:  sc_res = operand1 & operand2;
      OP_OR:   sc_res = operand1 | operand2;
      OP_XOR:  sc_res = operand1 ^ operand2;
      OP_NOT:  sc_res = ~operand1;
      OP_NOR:  sc_res = ~(operand1 | operand2);
      OP_NAND: sc_res = ~(operand1 & operand2);
      OP_XNOR: sc_res = ~(operand1 ^ operand2);
      default: sc_valid = 1'b0;
    endcase
    sc_flg = sc_valid ? {sc_v, sc_c, sc_res[WIDTH-1], sc_res == '0} : 4'b0000;
  end

  // One iteration: acc_hi/acc_lo hold product hi/lo (MUL) or remainder/quotient (DIV/MOD)
  always_comb begin
    msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, dv_q} : {(WIDTH+1){1'b0}});
    rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    trial  = rem_sh - {1'b0, dv_q};
    qbit   = !trial[WIDTH];
    if (op_q == OP_MUL) begin
      nx_hi = msum[WIDTH:1];
      nx_lo = {msum[0], acc_lo[WIDTH-1:1]};
    end else begin
      nx_hi = qbit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
      nx_lo = {acc_lo[WIDTH-2:0], qbit};
    end
    it_res = (op_q == OP_MOD) ? nx_hi : nx_lo;
    it_c   = (op_q == OP_MUL) && (nx_hi != '0);
    it_flg = {it_c, it_c, it_res[WIDTH-1], it_res == '0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: begin
        if (accept) state_nx = iter_op ? CALC : DONE;
        else        state_nx = IDLE;
      end
      CALC:    if (last_iter) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      dv_q   <= '0;
      acc_lo <= '0;
      acc_hi <= '0;
      cnt    <= '0;
      result <= '0;
      flags  <= '0;
    end else if (accept) begin
      op_q   <= ula_operation;
      dv_q   <= operand2;
      acc_lo <= operand1;
      acc_hi <= '0;
      cnt    <= '0;
      if (!iter_op) begin
        result <= sc_res;
        flags  <= sc_flg;
      end
    end else if (state == CALC) begin
      acc_lo <= nx_lo;
      acc_hi <= nx_hi;
      cnt    <= cnt + 1'b1;
      if (last_iter) begin
        result <= it_res;
        flags  <= it_flg;
      end
    end
  end
endmodule

// File: tb/tb_ula_seq.sv
// Randomized + directed bench for ula_seq (WIDTH=8) against an arithmetic reference model.
module tb_ula_seq;
  localparam int W = 8;
  localparam int M = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   ula_operation = '0;
  logic [W-1:0] operand1 = '0, operand2 = '0;
  logic         busy, done;
  logic [W-1:0] result;
  logic [3:0]   flags;

  int n_chk = 0;
  int n_fail = 0;

  ula_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ula_operation(ula_operation),
    .operand1(operand1), .operand2(operand2), .busy(busy), .done(done),
    .result(result), .flags(flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int sval(input int x);
    return (x >= (1 << (W-1))) ? x - (1 << W) : x;
  endfunction

  // Returns {flags, result}
  function automatic logic [11:0] model(input int op, input int a, input int b);
    int r, c, v, s;
    c = 0; v = 0;
    case (op)
      1: begin r = (a + b) & M; c = (a + b) > M; s = sval(a) + sval(b); v = (s > M/2) || (s < -(M/2) - 1); end
      2: begin r = (a - b) & M; c = a < b;       s = sval(a) - sval(b); v = (s > M/2) || (s < -(M/2) - 1); end
      3: begin r = (a * b) & M; c = ((a * b) >> W) != 0; v = c; end
      4: if (b == 0) begin r = 0; c = 1; end else r = a / b;
      5: if (b == 0) begin r = 0; c = 1; end else r = a % b;
      6: r = a & b;
      7: r = a | b;
      8: r = a ^ b;
      9: r = (~a) & M;
      10: r = (~(a | b)) & M;
      11: r = (~(a & b)) & M;
      12: r = (~(a ^ b)) & M;
      default: return 12'h000;
    endcase
    return {v[0], c[0], r[W-1], r == 0, r[W-1:0]};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke);
    logic [11:0] exp;
    int exp_busy, n;
    exp      = model(int'(op), int'(a), int'(b));
    exp_busy = (op == 4'd3 || ((op == 4'd4 || op == 4'd5) && b != 0)) ? W : 0;
    @(negedge clk);
    ula_operation = op; operand1 = a; operand2 = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    operand1 = W'($urandom); operand2 = W'($urandom); ula_operation = 4'($urandom);
    n = 0;
    while (busy && n < 100) begin
      if (poke) start = 1'($urandom);
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    chk($sformatf("busy_cycles op%0d", op), n, exp_busy);
    chk($sformatf("done op%0d", op), done, 1'b1);
    chk($sformatf("result op%0d a=%0d b=%0d", op, a, b), result, exp[W-1:0]);
    chk($sformatf("flags op%0d a=%0d b=%0d", op, a, b), flags, exp[11:8]);
    @(negedge clk);
    chk($sformatf("done_pulse op%0d", op), done, 1'b0);
    chk($sformatf("result_hold op%0d", op), result, exp[W-1:0]);
  endtask

  initial begin
    int dcount;
    #2;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset result", result, '0);
    chk("reset flags", flags, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd1,  8'd200, 8'd100, 1'b0);
    run_op(4'd2,  8'd5,   8'd7,   1'b0);
    run_op(4'd12, 8'hF0,  8'hF0,  1'b0);
    run_op(4'd3,  8'd20,  8'd13,  1'b1);
    run_op(4'd4,  8'd100, 8'd7,   1'b1);
    run_op(4'd5,  8'd100, 8'd7,   1'b0);
    run_op(4'd4,  8'd55,  8'd0,   1'b0);
    run_op(4'd15, 8'd12,  8'd34,  1'b0);
    run_op(4'd1,  8'd127, 8'd1,   1'b0);
    run_op(4'd2,  8'h80,  8'd1,   1'b0);
    run_op(4'd3,  8'd255, 8'd255, 1'b0);
    run_op(4'd5,  8'd9,   8'd0,   1'b0);
    run_op(4'd1,  8'd200, 8'd100, 1'b0);

    // Abort a MUL with reset partway through
    @(negedge clk);
    ula_operation = 4'd3; operand1 = 8'd255; operand2 = 8'd255; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort result", result, '0);
    chk("abort flags", flags, '0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("no done after abort", dcount, 0);
    run_op(4'd1, 8'd1, 8'd1, 1'b0);

    for (int i = 0; i < 60; i++)
      run_op(4'($urandom), W'($urandom), (($urandom % 8) == 0) ? W'(0) : W'($urandom), 1'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
